// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters.
// Optional result flags (carry/overflow/zero) are enabled by defining ADD_SHARE_FLAGS_EN.
module add_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_ans,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
`ifdef ADD_SHARE_FLAGS_EN
    ,
    output logic                  res_carry,
    output logic                  res_ovf,
    output logic                  res_zero
`endif
);

    // Handshake: req is a level held until gnt pulses; operands are sampled in
    // the cycle gnt is raised. res_valid is a one-cycle pulse with no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   sel;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic [IDW-1:0]   win;
    logic             win_any;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    int               idx;

    // Scan upward from rr_ptr with wrap; first set request bit wins.
    always_comb begin
        win     = '0;
        win_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_any && req[idx[IDW-1:0]]) begin
                win_any = 1'b1;
                win     = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = a_in[i*WIDTH +: WIDTH];
                win_b = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any) state_d = GRANT;
            GRANT:   state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            sel       <= '0;
            opa       <= '0;
            opb       <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        sel  <= win;
                        opa  <= win_a;
                        opb  <= win_b;
                        gnt  <= NREQ'(1) << win;
                        busy <= 1'b1;
                    end
                end
                GRANT: begin
                    add_a <= opa;
                    add_b <= opb;
                end
                EXEC: begin
                    res_data  <= add_ans;
                    res_id    <= sel;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    rr_ptr <= (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ADD_SHARE_FLAGS_EN
    // Flags derive from the latched operands, so they match the captured sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            res_zero  <= 1'b0;
        end else if (state_q == EXEC) begin
            res_carry <= (opa[WIDTH-1] & opb[WIDTH-1]) |
                         ((opa[WIDTH-1] | opb[WIDTH-1]) & ~add_ans[WIDTH-1]);
            res_ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) &
                         (add_ans[WIDTH-1] != opa[WIDTH-1]);
            res_zero  <= (add_ans == '0);
        end
    end
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: reset, round-robin, wrap/overflow,
// mid-operation reset and operand hold, with a queued result scoreboard.
module tb_add_share_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    localparam logic [15:0] RA [4] = '{16'h1111, 16'h2222, 16'hC333, 16'hF444};
    localparam logic [15:0] RB [4] = '{16'h0303, 16'h0404, 16'h4505, 16'h1606};
    localparam logic [15:0] RS [4] = '{16'h1414, 16'h2626, 16'h0838, 16'h0A4A};

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_ans;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic                  busy;
`ifdef ADD_SHARE_FLAGS_EN
    logic                  res_carry;
    logic                  res_ovf;
    logic                  res_zero;
`endif

    logic [IDW+WIDTH-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int n_pushed    = 0;
    int rv_count    = 0;

    add_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ans   (add_ans),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
`ifdef ADD_SHARE_FLAGS_EN
        ,
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .res_zero  (res_zero)
`endif
    );

    // Shared adder model: plain modulo-2^WIDTH sum.
    assign add_ans = add_a + add_b;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (res_valid === 1'b1) rv_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [WIDTH-1:0] sum);
        exp_q.push_back({IDW'(id), sum});
        n_pushed++;
    endtask

    task automatic check_result();
        logic [IDW+WIDTH-1:0] e;
        check("res_valid", 32'(res_valid), 32'd1);
        check("exp_q_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("res_id_data", 32'({res_id, res_data}), 32'(e));
        end
    endtask

    task automatic run_txn(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] sum);
        req = '0;
        req[id] = 1'b1;
        a_in[id*WIDTH +: WIDTH] = a;
        b_in[id*WIDTH +: WIDTH] = b;
        tick();
        check("txn_gnt", 32'(gnt), 32'(1) << id);
        push_exp(id, sum);
        req = '0;
        a_in[id*WIDTH +: WIDTH] = ~a;
        b_in[id*WIDTH +: WIDTH] = ~b;
        tick();
        check("txn_add_a", 32'(add_a), 32'(a));
        check("txn_add_b", 32'(add_b), 32'(b));
        tick();
        check_result();
        tick();
        check("txn_idle_busy", 32'(busy), 32'd0);
        check("txn_idle_rv", 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*WIDTH +: WIDTH] = RA[i];
            b_in[i*WIDTH +: WIDTH] = RB[i];
        end

        // Reset held three cycles with all requesters active.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_add_ab", 32'({add_a, add_b}), 32'd0);
            check("rst_res", 32'({res_id, res_data}), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Continuous requests: grants rotate 0,1,2,3,0 every four cycles.
        for (int g = 0; g < 5; g++) begin
            int id;
            id = g % NREQ;
            check("rr_gnt", 32'(gnt), 32'(1) << id);
            check("rr_busy", 32'(busy), 32'd1);
            push_exp(id, RS[id]);
            tick();
            check("rr_gnt_pulse", 32'(gnt), 32'd0);
            check("rr_add_a", 32'(add_a), 32'(RA[id]));
            check("rr_add_b", 32'(add_b), 32'(RB[id]));
            tick();
            check_result();
            if (g == 4) req = '0;
            tick();
            check("rr_rv_pulse", 32'(res_valid), 32'd0);
            tick();
        end
        check("rr_end_gnt", 32'(gnt), 32'd0);
        check("rr_end_busy", 32'(busy), 32'd0);

        // Single request with operand change after grant, then wrap cases.
        run_txn(2, 16'h1234, 16'h0001, 16'h1235);
        run_txn(3, 16'hFFFF, 16'h0002, 16'h0001);
`ifdef ADD_SHARE_FLAGS_EN
        check("flags_ffff_2", 32'({res_carry, res_ovf, res_zero}), 32'b100);
`endif
        run_txn(0, 16'h7FFF, 16'h0001, 16'h8000);
`ifdef ADD_SHARE_FLAGS_EN
        check("flags_7fff_1", 32'({res_carry, res_ovf, res_zero}), 32'b010);
`endif
        run_txn(1, 16'hFFFF, 16'h0001, 16'h0000);
`ifdef ADD_SHARE_FLAGS_EN
        check("flags_zero", 32'({res_carry, res_ovf, res_zero}), 32'b101);
`endif

        // Reset during EXEC; req[3] stays pending and is granted on release.
        req = 4'b1000;
        a_in[3*WIDTH +: WIDTH] = 16'h0100;
        b_in[3*WIDTH +: WIDTH] = 16'h0023;
        tick();
        check("abort1_gnt", 32'(gnt), 32'b1000);
        tick();
        check("abort1_exec_a", 32'(add_a), 32'h0100);
        rst = 1'b1;
        tick();
        check("abort1_rv", 32'(res_valid), 32'd0);
        check("abort1_busy", 32'(busy), 32'd0);
        check("abort1_add_a", 32'(add_a), 32'd0);
        rst = 1'b0;
        tick();
        check("abort1_regnt", 32'(gnt), 32'b1000);
        push_exp(3, 16'h0123);
        req = '0;
        tick();
        tick();
        check_result();
        tick();

        // Second abort from a nonzero pointer shows rr_ptr returns to 0.
        run_txn(1, 16'h0001, 16'h0001, 16'h0002);
        req = 4'b0100;
        tick();
        check("abort2_gnt", 32'(gnt), 32'b0100);
        tick();
        rst = 1'b1;
        req = 4'b1010;
        a_in[1*WIDTH +: WIDTH] = 16'h0F0F;
        b_in[1*WIDTH +: WIDTH] = 16'h1010;
        tick();
        check("abort2_rv", 32'(res_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("abort2_ptr_gnt", 32'(gnt), 32'b0010);
        push_exp(1, 16'h1F1F);
        req = '0;
        tick();
        tick();
        check_result();
        tick();
        tick();

        check("rv_count", 32'(rv_count), 32'(n_pushed));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
